// File: rtl/servo_cmd_if.sv
// rtl/servo_cmd_if.sv - UART byte input and servo position outputs of the command scheduler
interface servo_cmd_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] pos_x;
    logic [6:0] pos_y;
    logic       frame_sync;
    logic       cmd_ack;
    logic       cmd_err;

    // Byte source side (UART receiver / bench)
    modport master (
        output rx_data, rx_valid,
        input  pos_x, pos_y, frame_sync, cmd_ack, cmd_err
    );

    // Scheduler side
    modport slave (
        input  rx_data, rx_valid,
        output pos_x, pos_y, frame_sync, cmd_ack, cmd_err
    );
endinterface

// File: rtl/servo_cmd_scheduler.sv
// rtl/servo_cmd_scheduler.sv - UART command parser with frame-aligned, slew-limited servo positions
module servo_cmd_scheduler #(
    parameter int FRAME_TICKS = 129,
    parameter int MAX_STEP    = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int POS_INIT    = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    servo_cmd_if.slave  bus
);

    localparam int FW = $clog2(FRAME_TICKS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FW-1:0]      FRAME_LAST   = FW'(FRAME_TICKS - 1);
    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]         POS_RST      = 7'(POS_INIT);
    localparam logic [6:0]         STEP7        = 7'(MAX_STEP);
    localparam logic signed [7:0]  STEP8        = 8'(MAX_STEP);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AXIS = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]    state;
    logic          axis;
    logic [6:0]    tgt_x;
    logic [6:0]    tgt_y;
    logic [TW-1:0] tmo_cnt;
    logic [FW-1:0] frame_cnt;
    logic [6:0]    pos_x;
    logic [6:0]    pos_y;
    logic          frame_sync;
    logic          cmd_ack;
    logic          cmd_err;

    // Move one step toward the target; the difference is taken as 8-bit signed
    // so a target below the current position yields a negative delta.
    function automatic logic [6:0] slew(input logic [6:0] pos, input logic [6:0] tgt);
        logic signed [7:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, pos});
        if (d > STEP8)
            slew = pos + STEP7;
        else if (d < -STEP8)
            slew = pos - STEP7;
        else
            slew = tgt;
    endfunction

    // Frame timebase; positions advance on the same edge that raises frame_sync,
    // using the targets as they stood before any write on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_sync <= 1'b0;
            pos_x      <= POS_RST;
            pos_y      <= POS_RST;
        end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt  <= '0;
            frame_sync <= 1'b1;
            pos_x      <= slew(pos_x, tgt_x);
            pos_y      <= slew(pos_y, tgt_y);
        end else begin
            frame_cnt  <= frame_cnt + 1'b1;
            frame_sync <= 1'b0;
        end
    end

    // Three-byte command parser (FF, axis, position) with inter-byte timeout.
    // A received byte always wins over a timeout on the same edge, so ack and
    // err can never pulse together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            axis    <= 1'b0;
            tgt_x   <= POS_RST;
            tgt_y   <= POS_RST;
            tmo_cnt <= '0;
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
            if (bus.rx_valid) begin
                tmo_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (bus.rx_data == 8'hFF)
                            state <= AXIS;
                    end
                    AXIS: begin
                        if (bus.rx_data[7:1] == 7'd0) begin
                            axis  <= bus.rx_data[0];
                            state <= DATA;
                        end else if (bus.rx_data == 8'hFF) begin
                            cmd_err <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            cmd_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (!bus.rx_data[7]) begin
                            if (axis)
                                tgt_y <= bus.rx_data[6:0];
                            else
                                tgt_x <= bus.rx_data[6:0];
                            cmd_ack <= 1'b1;
                            state   <= IDLE;
                        end else if (bus.rx_data == 8'hFF) begin
                            state   <= AXIS;
                            cmd_err <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            cmd_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TIMEOUT_LAST) begin
                tmo_cnt <= '0;
                state   <= IDLE;
                cmd_err <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign bus.pos_x      = pos_x;
    assign bus.pos_y      = pos_y;
    assign bus.frame_sync = frame_sync;
    assign bus.cmd_ack    = cmd_ack;
    assign bus.cmd_err    = cmd_err;

endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// tb/tb_servo_cmd_scheduler.sv - self-checking bench for servo_cmd_scheduler
module tb_servo_cmd_scheduler;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_cmd_if bus();

    servo_cmd_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Protocol-level model: bytes of the pending command kept in a queue,
    // frame timing from the cycle count since reset release.
    int m_pos[2];
    int m_tgt[2];
    int m_cycle;
    int m_quiet;
    int m_b;
    int m_d;
    int cmdq[$];
    bit e_sync, e_ack, e_err;

    task automatic model_reset();
        m_pos[0] = 64; m_pos[1] = 64;
        m_tgt[0] = 64; m_tgt[1] = 64;
        m_cycle = 0; m_quiet = 0;
        cmdq.delete();
        e_sync = 0; e_ack = 0; e_err = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            e_ack = 0;
            e_err = 0;
            m_cycle++;
            e_sync = (m_cycle % 129 == 0);
            if (e_sync) begin
                for (int a = 0; a < 2; a++) begin
                    m_d = m_tgt[a] - m_pos[a];
                    if (m_d > 4)       m_pos[a] = m_pos[a] + 4;
                    else if (m_d < -4) m_pos[a] = m_pos[a] - 4;
                    else               m_pos[a] = m_tgt[a];
                end
            end
            if (bus.rx_valid) begin
                m_b = int'(bus.rx_data);
                m_quiet = 0;
                if (cmdq.size() == 0) begin
                    if (m_b == 255) cmdq.push_back(m_b);
                end else if (cmdq.size() == 1) begin
                    if (m_b <= 1) cmdq.push_back(m_b);
                    else if (m_b == 255) e_err = 1;
                    else begin e_err = 1; cmdq.delete(); end
                end else begin
                    if (m_b <= 127) begin
                        m_tgt[cmdq[1]] = m_b;
                        e_ack = 1;
                        cmdq.delete();
                    end else if (m_b == 255) begin
                        e_err = 1;
                        cmdq.delete();
                        cmdq.push_back(255);
                    end else begin
                        e_err = 1;
                        cmdq.delete();
                    end
                end
            end else if (cmdq.size() != 0) begin
                m_quiet++;
                if (m_quiet == 1024) begin
                    e_err = 1;
                    cmdq.delete();
                    m_quiet = 0;
                end
            end
        end
    end

    int ack_cnt = 0;
    int err_cnt = 0;

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("pos_x",      bus.pos_x,      m_pos[0]);
            check("pos_y",      bus.pos_y,      m_pos[1]);
            check("frame_sync", bus.frame_sync, int'(e_sync));
            check("cmd_ack",    bus.cmd_ack,    int'(e_ack));
            check("cmd_err",    bus.cmd_err,    int'(e_err));
            ack_cnt += int'(bus.cmd_ack);
            err_cnt += int'(bus.cmd_err);
        end
    end

    task automatic wait_sync(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_sync && n < 300);
        check("sync_seen", bus.frame_sync, 1);
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    int n, a0, e0;
    int exp2[5];
    int exp3[3];

    initial begin
        exp2 = '{68, 72, 76, 80, 80};
        exp3 = '{68, 72, 76};
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pos_x", bus.pos_x, 64);
        check("rst_pos_y", bus.pos_y, 64);
        check("rst_ack",   bus.cmd_ack, 0);
        check("rst_err",   bus.cmd_err, 0);
        rst_n = 1'b1;

        // 1: idle frames
        wait_sync(n);
        check("first_sync_gap", n, 129);
        wait_sync(n);
        check("sync_period", n, 129);
        check("t1_acks", ack_cnt, 0);
        check("t1_errs", err_cnt, 0);

        // 2: X to 0x50
        a0 = ack_cnt;
        send(8'hFF); send(8'h00); send(8'h50);
        repeat (2) @(negedge clk);
        check("t2_ack", ack_cnt - a0, 1);
        for (int i = 0; i < 5; i++) begin
            wait_sync(n);
            check("t2_pos_x", bus.pos_x, exp2[i]);
        end

        // 3: Y up toward 127, then reversed to 0
        send(8'hFF); send(8'h01); send(8'h7F);
        for (int i = 0; i < 3; i++) begin
            wait_sync(n);
            check("t3_pos_y_up", bus.pos_y, exp3[i]);
        end
        send(8'hFF); send(8'h01); send(8'h00);
        wait_sync(n);
        check("t3_pos_y_reverse", bus.pos_y, 72);
        repeat (18) wait_sync(n);
        check("t3_pos_y_floor", bus.pos_y, 0);
        wait_sync(n);
        check("t3_pos_y_hold", bus.pos_y, 0);

        // 4: malformed commands
        e0 = err_cnt; a0 = ack_cnt;
        send(8'hFF); send(8'h02);
        repeat (2) @(negedge clk);
        check("t4_bad_axis_err", err_cnt - e0, 1);
        send(8'hFF); send(8'h00); send(8'h90);
        repeat (2) @(negedge clk);
        check("t4_bad_pos_err", err_cnt - e0, 2);
        check("t4_bad_pos_ack", ack_cnt - a0, 0);
        send(8'hFF); send(8'hFF); send(8'h01); send(8'h10);
        repeat (2) @(negedge clk);
        check("t4_resync_err", err_cnt - e0, 3);
        check("t4_resync_ack", ack_cnt - a0, 1);
        wait_sync(n);
        check("t4_pos_y", bus.pos_y, 4);
        check("t4_pos_x_kept", bus.pos_x, 80);

        // 5: timeout
        e0 = err_cnt; a0 = ack_cnt;
        send(8'hFF); send(8'h00);
        repeat (1000) @(negedge clk);
        check("t5_no_early_err", err_cnt - e0, 0);
        repeat (30) @(negedge clk);
        check("t5_timeout_err", err_cnt - e0, 1);
        send(8'h30);
        repeat (5) @(negedge clk);
        check("t5_after_err", err_cnt - e0, 1);
        check("t5_after_ack", ack_cnt - a0, 0);

        // 6: reset mid-slew and mid-command
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check("t6_async_pos_x", bus.pos_x, 64);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sync(n);
        check("t6_sync_restart", n, 129);
        send(8'hFF); send(8'h00); send(8'h50);
        wait_sync(n);
        wait_sync(n);
        check("t6_pos_x_mid", bus.pos_x, 72);
        send(8'hFF); send(8'h00);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 check("t6_snap_pos_x", bus.pos_x, 64);
        check("t6_snap_pos_y", bus.pos_y, 64);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        a0 = ack_cnt;
        send(8'h10);
        repeat (4) @(negedge clk);
        check("t6_partial_discarded", ack_cnt - a0, 0);
        repeat (3) wait_sync(n);
        check("t6_no_resume", bus.pos_x, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
